// File: rtl/riscv_pkg.sv
// riscv_pkg: immediate-type codes, base opcodes and buffer state encoding
package riscv_pkg;
    localparam logic [2:0] RTYPE  = 3'b000;
    localparam logic [2:0] ITYPE  = 3'b001;
    localparam logic [2:0] STYPE  = 3'b010;
    localparam logic [2:0] BTYPE  = 3'b011;
    localparam logic [2:0] UTYPE  = 3'b100;
    localparam logic [2:0] JTYPE  = 3'b101;
    localparam logic [2:0] LITYPE = 3'b110;
    localparam logic [2:0] JITYPE = 3'b111;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
endpackage

// File: rtl/imm_type_decode.sv
// imm_type_decode: maps a 7-bit opcode to its immediate-type code and illegal flag
module imm_type_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_type,
    output logic       illegal
);
    always_comb begin
        imm_type = RTYPE;
        illegal  = 1'b0;
        case (opcode)
            OP_OP:             imm_type = RTYPE;
            OP_IMM:            imm_type = ITYPE;
            OP_STORE:          imm_type = STYPE;
            OP_BRANCH:         imm_type = BTYPE;
            OP_LUI, OP_AUIPC:  imm_type = UTYPE;
            OP_JAL:            imm_type = JTYPE;
            OP_LOAD:           imm_type = LITYPE;
            OP_JALR:           imm_type = JITYPE;
            default:           illegal  = 1'b1;
        endcase
    end
endmodule

// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: two-entry skid buffer between fetch and decode;
// opcodes are classified at enqueue so every output comes straight from a flop.
module fetch_decode_buffer
    import riscv_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [24:0]     out_imm_field,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal
);
    state_t          state;
    logic [PC_W-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic [2:0]      skid_type;
    logic            skid_illegal;
    logic [2:0]      dec_type;
    logic            dec_illegal;
    logic            accept;
    logic            pop;

    imm_type_decode u_dec (
        .opcode   (in_instr[6:0]),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign accept        = in_valid & in_ready;
    assign pop           = out_valid & out_ready;
    assign out_imm_field = out_instr[31:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
            out_pc       <= '0;
            out_instr    <= '0;
            out_imm_type <= RTYPE;
            out_illegal  <= 1'b0;
            skid_pc      <= '0;
            skid_instr   <= '0;
            skid_type    <= RTYPE;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state        <= ONE;
                    out_valid    <= 1'b1;
                    out_pc       <= in_pc;
                    out_instr    <= in_instr;
                    out_imm_type <= dec_type;
                    out_illegal  <= dec_illegal;
                end
                ONE: if (pop && accept) begin
                    out_pc       <= in_pc;
                    out_instr    <= in_instr;
                    out_imm_type <= dec_type;
                    out_illegal  <= dec_illegal;
                end else if (pop) begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end else if (accept) begin
                    state        <= FULL;
                    in_ready     <= 1'b0;
                    skid_pc      <= in_pc;
                    skid_instr   <= in_instr;
                    skid_type    <= dec_type;
                    skid_illegal <= dec_illegal;
                end
                // in_ready is low here, so no new beat can arrive alongside the pop
                FULL: if (pop) begin
                    state        <= ONE;
                    in_ready     <= 1'b1;
                    out_pc       <= skid_pc;
                    out_instr    <= skid_instr;
                    out_imm_type <= skid_type;
                    out_illegal  <= skid_illegal;
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb_fetch_decode_buffer: directed scenarios plus a scoreboard that checks
// every popped beat against the order and classification of accepted beats.
module tb_fetch_decode_buffer;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  typ;
        logic        ill;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [24:0] out_imm_field;
    logic [2:0]  out_imm_type;
    logic        out_illegal;

    int    n_checks = 0;
    int    n_fail = 0;
    beat_t sb[$];

    fetch_decode_buffer #(.PC_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_instr      (in_instr),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_imm_field (out_imm_field),
        .out_imm_type  (out_imm_type),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    function automatic beat_t model(input logic [31:0] pc, input logic [31:0] instr);
        beat_t b;
        b.pc    = pc;
        b.instr = instr;
        b.ill   = 1'b0;
        case (instr[6:0])
            7'h33:        b.typ = 3'd0;
            7'h13:        b.typ = 3'd1;
            7'h23:        b.typ = 3'd2;
            7'h63:        b.typ = 3'd3;
            7'h37, 7'h17: b.typ = 3'd4;
            7'h6F:        b.typ = 3'd5;
            7'h03:        b.typ = 3'd6;
            7'h67:        b.typ = 3'd7;
            default: begin
                b.typ = 3'd0;
                b.ill = 1'b1;
            end
        endcase
        return b;
    endfunction

    // Inputs change just after posedge, so the negedge sees exactly what the next edge will act on
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_pop: got pc=%h instr=%h, required no beat (queue empty)", out_pc, out_instr);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    if ({out_pc, out_instr, out_imm_type, out_illegal, out_imm_field} !==
                        {e.pc, e.instr, e.typ, e.ill, e.instr[31:7]}) begin
                        n_fail++;
                        $display("FAIL sb_beat: got pc=%h instr=%h type=%b ill=%b field=%h, required pc=%h instr=%h type=%b ill=%b field=%h",
                                 out_pc, out_instr, out_imm_type, out_illegal, out_imm_field,
                                 e.pc, e.instr, e.typ, e.ill, e.instr[31:7]);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_pc, in_instr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_hs: got valid=%b ready=%b, required valid=0 ready=1", out_valid, in_ready);
        end
        n_checks++;
        if ({out_pc, out_instr, out_imm_field, out_imm_type, out_illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got pc=%h instr=%h field=%h type=%b ill=%b, required all zero",
                     out_pc, out_instr, out_imm_field, out_imm_type, out_illegal);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h100;
        in_instr  = 32'h00500093;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_pc, out_imm_type, out_imm_field, out_illegal} !==
            {1'b1, 32'h100, 3'b001, 25'h000A001, 1'b0}) begin
            n_fail++;
            $display("FAIL single: got valid=%b pc=%h type=%b field=%h ill=%b, required valid=1 pc=00000100 type=001 field=000a001 ill=0",
                     out_valid, out_pc, out_imm_type, out_imm_field, out_illegal);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins[5] = '{32'h00112023, 32'h0000006F, 32'h00008067, 32'h00002083, 32'h000000B7};
        logic [2:0]  typ[5] = '{3'b010, 3'b101, 3'b111, 3'b110, 3'b100};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h200 + 32'(4 * i);
            in_instr = ins[i];
            tick();
            n_checks++;
            if ({out_valid, in_ready, out_imm_type, out_instr} !== {1'b1, 1'b1, typ[i], ins[i]}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got valid=%b ready=%b type=%b instr=%h, required valid=1 ready=1 type=%b instr=%h",
                         i, out_valid, in_ready, out_imm_type, out_instr, typ[i], ins[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] ins[3] = '{32'h00A00113, 32'h00B00193, 32'h00C00213};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h300 + 32'(4 * i);
            in_instr = ins[i];
            tick();
            n_checks++;
            if ({out_valid, in_ready, out_instr} !== {1'b1, i == 0, ins[0]}) begin
                n_fail++;
                $display("FAIL stall_%0d: got valid=%b ready=%b instr=%h, required valid=1 ready=%b instr=%h",
                         i, out_valid, in_ready, out_instr, i == 0, ins[0]);
            end
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({in_ready, out_instr} !== {1'b1, ins[1]}) begin
            n_fail++;
            $display("FAIL stall_pop_full: got ready=%b instr=%h, required ready=1 instr=%h", in_ready, out_instr, ins[1]);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_instr} !== {1'b1, ins[2]}) begin
            n_fail++;
            $display("FAIL stall_c: got valid=%b instr=%h, required valid=1 instr=%h", out_valid, out_instr, ins[2]);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h400 + 32'(4 * i);
            in_instr = 32'h00100093 + 32'(i << 20);
            tick();
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_full: got ready=%b, required 0", in_ready);
        end
        flush    = 1'b1;
        in_pc    = 32'h4FC;
        in_instr = 32'h7FF00093;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush: got valid=%b ready=%b, required valid=0 ready=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: got valid=%b instr=%h, required valid=0", out_valid, out_instr);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h500;
        in_instr  = 32'hFFFFFFFF;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_illegal, out_imm_type} !== {1'b1, 1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL illegal: got valid=%b ill=%b type=%b, required valid=1 ill=1 type=000",
                     out_valid, out_illegal, out_imm_type);
        end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h600 + 32'(4 * i);
            in_instr = 32'h00000033 + 32'(i << 7);
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL areset_full: got valid=%b ready=%b, required valid=1 ready=0", out_valid, in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        sb.delete();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL areset_now: got valid=%b ready=%b, required valid=0 ready=1", out_valid, in_ready);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_after: got valid=%b, required 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_illegal();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d beats outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_decode_buffer.md
# fetch_decode_buffer

Two-entry elastic buffer between instruction fetch and the decode/immediate-generation stage. It accepts {PC, instruction} beats from fetch with a valid/ready handshake. At enqueue time it classifies each instruction by opcode into the 3-bit immediate-type code. It presents registered PC, instruction, the 25-bit immediate field (instr[31:7]) and the type code to the immediate generator and decoder, and absorbs one cycle of downstream stall without a combinational ready path.

## Interface
- PC_W, 32, width of program counter

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  fetch beat present
- in_ready  output  1  buffer can accept; registered
- in_pc  input  PC_W  PC of fetched instruction
- in_instr  input  32  fetched instruction word
- flush  input  1  synchronous kill of all buffered beats (branch redirect)
- out_valid  output  1  head entry valid
- out_ready  input  1  decode consumes head
- out_pc  output  PC_W  head PC
- out_instr  output  32  head instruction
- out_imm_field  output  25  head instr[31:7]
- out_imm_type  output  3  immediate type code of head
- out_illegal  output  1  head opcode unrecognised

One clock; reset is asynchronous and active-low.

## Operation
- Type encoding, decoded from instr[6:0]:
  - 0110011 → 000 R
  - 0010011 → 001 I
  - 0100011 → 010 S
  - 1100011 → 011 B
  - 0110111 and 0010111 → 100 U
  - 1101111 → 101 J
  - 0000011 → 110 LI (load)
  - 1100111 → 111 JI (JALR)
  - any other opcode → 000 with illegal=1.
- Entries: main (drives out_*) and skid. Each holds pc, instr, type, illegal. The decode result is stored at enqueue, so no output has a combinational path from an input.
- Handshake fires: accept = in_valid & in_ready; pop = out_valid & out_ready.
- State machine:
  - EMPTY (out_valid=0, in_ready=1): accept → ONE; main loads input.
  - ONE (out_valid=1, in_ready=1):
    - pop & accept → ONE, main loads input.
    - pop only → EMPTY.
    - accept only → FULL, skid loads input.
    - neither → ONE.
  - FULL (out_valid=1, in_ready=0): pop → ONE, main loads skid; otherwise hold.
- flush: next state EMPTY regardless of the current state, accept or pop. A beat offered in the flush cycle is dropped. in_ready=1 in the following cycle.
- Ordering: strict FIFO. No beat is duplicated or lost except by flush.
- Data registers need not clear on flush, but out_* data must be stable while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - out_valid=0, in_ready=1.
  - out_pc=0, out_instr=0, out_imm_field=0, out_imm_type=000, out_illegal=0.
  - State EMPTY.
- Latency: a beat accepted in cycle N is on out_* with out_valid=1 in cycle N+1 if the buffer was EMPTY, or in ONE with a simultaneous pop.
- Throughput: one beat per cycle sustained while out_ready=1.
- in_ready falls in the cycle after an accept that made the buffer FULL. It rises in the cycle after the pop from FULL.
- Reset assertion mid-stream returns to EMPTY immediately (asynchronous); all in-flight beats are discarded.
- flush together with reset has no additional effect.

## Structure
- Shared package riscv_pkg holds:
  - type-code constants RTYPE..JITYPE (000–111), the same values the immediate generator uses;
  - opcode constants OP_OP, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_LOAD, OP_JALR;
  - state enumeration EMPTY/ONE/FULL.
- One combinational sub-module imm_type_decode (instr[6:0] → type, illegal), instantiated once on the input path.

## Test plan
- Reset, then offer 0x00500093 (addi x1,x0,5) at PC 0x100 with out_ready=1 → next cycle out_valid=1, out_pc=0x100, out_imm_type=001, out_imm_field=0x000A001, out_illegal=0.
- Stream 0x00112023, 0x0000006F, 0x00008067, 0x00002083, 0x000000B7 back-to-back with out_ready=1 → types 010, 101, 111, 110, 100 in order, one per cycle, in_ready constantly 1.
- Hold out_ready=0 and offer three beats A, B, C → A on out, B in skid, in_ready=0 after B is accepted, C not accepted. Raise out_ready → A, B, C emerge in order with no loss.
- In FULL, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the offered beat never appears.
- Offer 0xFFFFFFFF → out_illegal=1, out_imm_type=000.
- Deassert rst_n while FULL → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
